// File: rtl/plru_replacement_controller_if.sv
// Lookup/victim/touch bundle between the miss/refill sequencer and the PLRU controller.
// Widths derive from the same cache geometry parameters the controller uses.
interface plru_replacement_controller_if #(
  parameter int S = 17,
  parameter int B = 9,
  parameter int a = 1
);
  localparam int SET_W = S - a - B;

  logic             INIT_DONE;
  logic             LOOKUP_VALID;
  logic [SET_W-1:0] LOOKUP_SET;
  logic             LOOKUP_READY;
  logic             VICTIM_VALID;
  logic [a-1:0]     VICTIM_WAY;
  logic             TOUCH_VALID;
  logic [SET_W-1:0] TOUCH_SET;
  logic [a-1:0]     TOUCH_WAY;

  modport master (
    output LOOKUP_VALID, LOOKUP_SET, TOUCH_VALID, TOUCH_SET, TOUCH_WAY,
    input  INIT_DONE, LOOKUP_READY, VICTIM_VALID, VICTIM_WAY
  );

  modport slave (
    input  LOOKUP_VALID, LOOKUP_SET, TOUCH_VALID, TOUCH_SET, TOUCH_WAY,
    output INIT_DONE, LOOKUP_READY, VICTIM_VALID, VICTIM_WAY
  );
endinterface

// File: rtl/plru_replacement_controller.sv
// Tree pseudo-LRU victim selector; REPLACE_RANDOM_EN swaps the tree for a 16-bit LFSR.
// Victim 1 cycle after accept; READY low during init sweep and the response cycle.
module plru_replacement_controller #(
  parameter int S = 17,
  parameter int B = 9,
  parameter int a = 1
) (
  input logic CLK,
  input logic RSTN,
  plru_replacement_controller_if.slave bus
);
  localparam int SET_W = S - a - B;
  localparam int SETS  = 1 << SET_W;
  localparam int NODES = (1 << a) - 1;

  typedef enum logic [1:0] {INIT, IDLE, RESP} state_t;

  state_t           state;
  logic [SET_W-1:0] sweep_idx;
  logic             init_done;
  logic             lookup_ready;
  logic             victim_valid;
  logic [a-1:0]     victim_way;
  logic [a-1:0]     next_way;
  logic             accept;

  assign accept = (state == IDLE) && bus.LOOKUP_VALID;

`ifdef REPLACE_RANDOM_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign next_way  = lfsr_next[a-1:0];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      lfsr <= 16'hACE1;
    end else if (accept) begin
      lfsr <= lfsr_next;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{bus.LOOKUP_SET, bus.TOUCH_VALID, bus.TOUCH_SET, bus.TOUCH_WAY};
`else
  logic [NODES-1:0] tree [SETS];

  // Tree bits are padded to 8 so a 3-bit heap index covers every legal associativity.
  function automatic logic [a-1:0] walk(input logic [NODES-1:0] t);
    logic [7:0] tp;
    logic [2:0] node;
    logic [2:0] acc;
    logic       b;
    tp   = 8'(t);
    node = 3'd0;
    acc  = 3'd0;
    for (int l = 0; l < a; l++) begin
      b    = tp[node];
      acc  = {acc[1:0], b};
      node = {node[1:0], 1'b0} + 3'd1 + {2'b00, b};
    end
    return acc[a-1:0];
  endfunction

  function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t, input logic [a-1:0] w);
    logic [7:0] tp;
    logic [2:0] node;
    logic [2:0] wp;
    logic       b;
    tp   = 8'(t);
    node = 3'd0;
    wp   = 3'(w) << (3 - a);
    for (int l = 0; l < a; l++) begin
      b        = wp[2];
      tp[node] = ~b;
      node     = {node[1:0], 1'b0} + 3'd1 + {2'b00, b};
      wp       = {wp[1:0], 1'b0};
    end
    return tp[NODES-1:0];
  endfunction

  // Victim is taken from the pre-edge array, so a same-edge touch never affects it.
  assign next_way = walk(tree[bus.LOOKUP_SET]);

  always_ff @(posedge CLK) begin
    if (state == INIT) begin
      tree[sweep_idx] <= '0;
    end else if (bus.TOUCH_VALID) begin
      tree[bus.TOUCH_SET] <= touch(tree[bus.TOUCH_SET], bus.TOUCH_WAY);
    end
  end
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state        <= INIT;
      sweep_idx    <= '0;
      init_done    <= 1'b0;
      lookup_ready <= 1'b0;
      victim_valid <= 1'b0;
      victim_way   <= '0;
    end else begin
      case (state)
        INIT: begin
          sweep_idx <= sweep_idx + SET_W'(1);
          if (sweep_idx == SET_W'(SETS - 1)) begin
            state        <= IDLE;
            init_done    <= 1'b1;
            lookup_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            state        <= RESP;
            lookup_ready <= 1'b0;
            victim_valid <= 1'b1;
            victim_way   <= next_way;
          end
        end
        RESP: begin
          state        <= IDLE;
          victim_valid <= 1'b0;
          lookup_ready <= 1'b1;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  assign bus.INIT_DONE    = init_done;
  assign bus.LOOKUP_READY = lookup_ready;
  assign bus.VICTIM_VALID = victim_valid;
  assign bus.VICTIM_WAY   = victim_way;
endmodule

// File: tb/tb_plru_replacement_controller.sv
// Directed bench for the PLRU controller: a=1 (128 sets) and a=2 (64 sets) instances.
// Define REPLACE_RANDOM_EN to check the LFSR build instead of the tree.
module tb_plru_replacement_controller;
  logic CLK;
  logic RSTN;
  int   checks;
  int   failures;

  plru_replacement_controller_if #(.S(17), .B(9), .a(1)) b1 ();
  plru_replacement_controller_if #(.S(17), .B(9), .a(2)) b2 ();

  plru_replacement_controller #(.S(17), .B(9), .a(1)) u1 (.CLK(CLK), .RSTN(RSTN), .bus(b1));
  plru_replacement_controller #(.S(17), .B(9), .a(2)) u2 (.CLK(CLK), .RSTN(RSTN), .bus(b2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic look1(input logic [6:0] set, input logic exp, input string tag);
    for (int n = 0; n < 50 && !b1.LOOKUP_READY; n++) step();
    chk({tag, "_rdy"}, b1.LOOKUP_READY, 1);
    b1.LOOKUP_VALID = 1'b1;
    b1.LOOKUP_SET   = set;
    step();
    b1.LOOKUP_VALID = 1'b0;
    chk({tag, "_vld"}, b1.VICTIM_VALID, 1);
    chk(tag, b1.VICTIM_WAY, exp);
    step();
    chk({tag, "_vld_drop"}, b1.VICTIM_VALID, 0);
  endtask

  task automatic look2(input logic [5:0] set, input logic [1:0] exp, input string tag);
    for (int n = 0; n < 50 && !b2.LOOKUP_READY; n++) step();
    chk({tag, "_rdy"}, b2.LOOKUP_READY, 1);
    b2.LOOKUP_VALID = 1'b1;
    b2.LOOKUP_SET   = set;
    step();
    b2.LOOKUP_VALID = 1'b0;
    chk({tag, "_vld"}, b2.VICTIM_VALID, 1);
    chk(tag, b2.VICTIM_WAY, exp);
    step();
    chk({tag, "_vld_drop"}, b2.VICTIM_VALID, 0);
  endtask

  task automatic touch1(input logic [6:0] set, input logic way);
    b1.TOUCH_VALID = 1'b1;
    b1.TOUCH_SET   = set;
    b1.TOUCH_WAY   = way;
    step();
    b1.TOUCH_VALID = 1'b0;
  endtask

  task automatic touch2(input logic [5:0] set, input logic [1:0] way);
    b2.TOUCH_VALID = 1'b1;
    b2.TOUCH_SET   = set;
    b2.TOUCH_WAY   = way;
    step();
    b2.TOUCH_VALID = 1'b0;
  endtask

  // Counts edges after RSTN rises until each INIT_DONE goes high.
  task automatic measure_init(input string tag);
    int r1;
    int r2;
    logic early;
    r1 = 0;
    r2 = 0;
    early = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      step();
      if (!b1.INIT_DONE && b1.LOOKUP_READY) early = 1'b1;
      if (b1.INIT_DONE && r1 == 0) r1 = c;
      if (b2.INIT_DONE && r2 == 0) r2 = c;
      if (r1 != 0 && r2 != 0) break;
    end
    chk({tag, "_a1_cycles"}, r1, 128);
    chk({tag, "_a2_cycles"}, r2, 64);
    chk({tag, "_ready_early"}, early, 0);
    chk({tag, "_ready_at_done"}, b1.LOOKUP_READY, 1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RSTN     = 1'b0;
    b1.LOOKUP_VALID = 1'b0; b1.LOOKUP_SET = '0;
    b1.TOUCH_VALID  = 1'b0; b1.TOUCH_SET  = '0; b1.TOUCH_WAY = '0;
    b2.LOOKUP_VALID = 1'b0; b2.LOOKUP_SET = '0;
    b2.TOUCH_VALID  = 1'b0; b2.TOUCH_SET  = '0; b2.TOUCH_WAY = '0;

    repeat (3) step();
    chk("rst_init_done", b1.INIT_DONE, 0);
    chk("rst_ready", b1.LOOKUP_READY, 0);
    chk("rst_victim_valid", b1.VICTIM_VALID, 0);
    chk("rst_victim_way", b1.VICTIM_WAY, 0);
    chk("rst_a2_victim_way", b2.VICTIM_WAY, 0);
    RSTN = 1'b1;
    measure_init("init");

`ifndef REPLACE_RANDOM_EN
    look1(7'd6, 1'b0, "a1_s6_start");
    look1(7'd5, 1'b0, "a1_s5_fresh");
    touch1(7'd5, 1'b0);
    look1(7'd5, 1'b1, "a1_s5_t0");
    touch1(7'd5, 1'b1);
    look1(7'd5, 1'b0, "a1_s5_t1");
    look1(7'd6, 1'b0, "a1_s6_end");

    // Lookup and touch of the same fresh set on one edge: read-first.
    b1.LOOKUP_VALID = 1'b1; b1.LOOKUP_SET = 7'd9;
    b1.TOUCH_VALID  = 1'b1; b1.TOUCH_SET  = 7'd9; b1.TOUCH_WAY = 1'b0;
    step();
    b1.LOOKUP_VALID = 1'b0; b1.TOUCH_VALID = 1'b0;
    chk("a1_s9_same_vld", b1.VICTIM_VALID, 1);
    chk("a1_s9_same_way", b1.VICTIM_WAY, 0);
    step();
    look1(7'd9, 1'b1, "a1_s9_after");

    touch2(6'd3, 2'd0);
    look2(6'd3, 2'd2, "a2_s3_t0");
    touch2(6'd3, 2'd2);
    look2(6'd3, 2'd1, "a2_s3_t2");
    touch2(6'd3, 2'd1);
    look2(6'd3, 2'd3, "a2_s3_t1");
    step();
    chk("a2_way_hold", b2.VICTIM_WAY, 3);

    touch1(7'd5, 1'b0);
    b1.LOOKUP_VALID = 1'b1; b1.LOOKUP_SET = 7'd5;
    step();
    b1.LOOKUP_VALID = 1'b0;
    chk("resp_pre_reset_way", b1.VICTIM_WAY, 1);
    #2 RSTN = 1'b0;
    #1;
    chk("resp_reset_vld", b1.VICTIM_VALID, 0);
    chk("resp_reset_way", b1.VICTIM_WAY, 0);
`else
    look2(6'd3, 2'd3, "rnd_1");
    touch2(6'd3, 2'd0);
    look2(6'd3, 2'd3, "rnd_2");
    touch2(6'd3, 2'd3);
    look2(6'd3, 2'd3, "rnd_3");
    look2(6'd7, 2'd2, "rnd_4");
    step();
    chk("rnd_way_hold", b2.VICTIM_WAY, 2);

    b2.LOOKUP_VALID = 1'b1; b2.LOOKUP_SET = 6'd5;
    step();
    b2.LOOKUP_VALID = 1'b0;
    chk("rnd_resp_pre_reset_vld", b2.VICTIM_VALID, 1);
    chk("rnd_resp_pre_reset_way", b2.VICTIM_WAY, 0);
    #2 RSTN = 1'b0;
    #1;
    chk("resp_reset_vld", b2.VICTIM_VALID, 0);
`endif
    chk("resp_reset_init_done", b1.INIT_DONE, 0);
    chk("resp_reset_ready", b1.LOOKUP_READY, 0);
    step();
    RSTN = 1'b1;

    // Interrupt the sweep when its index has reached 60.
    repeat (60) @(posedge CLK);
    #2 RSTN = 1'b0;
    #1;
    chk("sweep_reset_init_done", b1.INIT_DONE, 0);
    chk("sweep_reset_a2_init_done", b2.INIT_DONE, 0);
    step();
    RSTN = 1'b1;
    measure_init("reinit");

`ifndef REPLACE_RANDOM_EN
    look1(7'd5, 1'b0, "a1_s5_after_reset");
`else
    look2(6'd3, 2'd3, "rnd_reseeded");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/plru_replacement_controller.md
# plru_replacement_controller

Tree pseudo-LRU victim selector for the set-associative cache: it holds per-set replacement state, answers victim-way lookups from the cache miss path, and updates state on every hit or refill. It sits between the cache controller's miss/refill sequencer and the tag/data arrays. It supplies the way index to overwrite on refill.

## Interface
- S, 17, cache size is 2^S bits
- B, 9, block size is 2^B bits
- a, 1, associativity is 2^a ways; legal range 1..3
- Derived: SET_W = S - a - B; SETS = 2^SET_W; NODES = 2^a - 1 tree bits per set

- CLK  in  1  single clock, rising edge
- RSTN  in  1  asynchronous, active-low reset
- INIT_DONE  out  1  high once the state-array clear sweep has finished
- LOOKUP_VALID  in  1  victim request
- LOOKUP_SET  in  SET_W  set index of the request
- LOOKUP_READY  out  1  request accepted this cycle when high together with LOOKUP_VALID
- VICTIM_VALID  out  1  one-cycle pulse; VICTIM_WAY is valid
- VICTIM_WAY  out  a  way to replace
- TOUCH_VALID  in  1  mark a way most-recently-used (hit or refill complete)
- TOUCH_SET  in  SET_W  set index of the touch
- TOUCH_WAY  in  a  way that was used

## Operation
- The state array is SETS x NODES bits. Nodes are heap-indexed: root is 0; the children of node i are 2i+1 (branch 0, lower half) and 2i+2 (branch 1).
- Victim walk: start at the root. Node bit 0 means go to branch 0; node bit 1 means go to branch 1. The a branch decisions, MSB first, form VICTIM_WAY.
- Touch of way w: at each level l on w's path, the node bit is written as ~w[a-1-l], so the node points away from w. Nodes off the path are unchanged.
- FSM states:
  - INIT: clear one set per cycle, index 0..SETS-1. Goes to IDLE after set SETS-1 is cleared.
  - IDLE: LOOKUP_READY=1. An accepted lookup registers the set and goes to RESP.
  - RESP: VICTIM_VALID=1, LOOKUP_READY=0. Returns to IDLE next cycle.
- Touches are applied in IDLE and RESP and ignored in INIT.
- Simultaneous lookup and touch to the same set: the lookup reads state from before the touch (read-first).
- Touch and the RESP read of the same set in the same cycle: the victim uses state from before the touch.
- Out-of-range SET indices cannot occur, because the width is exact.

## Timing
- Reset values:
  - INIT_DONE=0, LOOKUP_READY=0, VICTIM_VALID=0, VICTIM_WAY=0, FSM=INIT, sweep index=0.
- INIT_DONE rises SETS cycles after RSTN deasserts (SETS=128 at default parameters) and stays high until the next reset.
- Lookup latency is 1 cycle. Accepted at edge t means VICTIM_VALID is high for exactly cycle t+1.
- Maximum lookup throughput is one every 2 cycles.
- A touch at edge t is visible to a lookup accepted at edge t+1 or later.
- VICTIM_WAY holds its last value after VICTIM_VALID falls.
- Reset asserted mid-lookup or mid-sweep:
  - all outputs return to their reset values immediately (asynchronously);
  - the sweep restarts from set 0;
  - the pending victim is dropped.

## Configuration
- REPLACE_RANDOM_EN defined:
  - the PLRU array and touch logic are removed; TOUCH_* are ignored.
  - VICTIM_WAY is the low a bits of a 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded 16'hACE1 on reset.
  - The LFSR advances once per accepted lookup.
  - INIT sweep timing is kept, so INIT_DONE behaves identically.
- Undefined: tree-PLRU as described above.

## Test plan
- Reset, then count cycles -> INIT_DONE rises exactly 128 cycles after RSTN deasserts (defaults); LOOKUP_READY=0 until then.
- a=1: lookup set 5 -> VICTIM_WAY=0. Touch way 0 on set 5, then lookup -> 1. Touch way 1, then lookup -> 0. Lookups on set 6 stay 0 throughout.
- a=2, all touches to set 3:
  - touch way 0 -> lookup gives 2;
  - then touch way 2 -> lookup gives 1;
  - then touch way 1 -> lookup gives 3.
- Same-cycle lookup and touch of way 0 on fresh set 9 (a=1) -> VICTIM_WAY=0 (read-first); the next lookup gives 1.
- RSTN pulsed low during RESP of a lookup and during sweep index 60:
  - VICTIM_VALID drops at once;
  - the sweep restarts, with INIT_DONE 128 cycles later;
  - set 5's previous state reads back as way 0.
- REPLACE_RANDOM_EN, a=2:
  - first three lookups -> low two bits of the LFSR sequence after 1, 2 and 3 advances from seed 16'hACE1;
  - touches have no effect.
